// File: rtl/channel_scanner.sv
// Round-robin channel scanner: dwells DWELL cycles on each masked-in channel,
// or follows man_sel in manual mode, and registers the selected channel data.
module channel_scanner #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int DWELL    = 1,
   localparam int SEL_W   = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en,
   input  logic                      clr,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          man_sel,
   input  logic [CHANNELS-1:0]       ch_mask,
   input  logic [CHANNELS*WIDTH-1:0] data_in,
   output logic [SEL_W-1:0]          sel,
   output logic [WIDTH-1:0]          data_out,
   output logic                      valid,
   output logic                      wrap,
   output logic                      none
);

   localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

   logic [15:0]      dwell, dwell_n;
   logic [SEL_W-1:0] sel_n, adv_sel, low_sel;
   logic             wrap_n, found;
   logic             man_ok;
   int               idx;

   assign none   = (ch_mask == '0);
   assign man_ok = int'(man_sel) < CHANNELS;

   // Next enabled channel searching upward from sel+1; the last candidate is
   // sel itself, so a lone enabled channel maps back onto itself.
   always_comb begin
      adv_sel = sel;
      found   = 1'b0;
      idx     = 0;
      for (int i = 1; i <= CHANNELS; i++) begin
         idx = (int'(sel) + i) % CHANNELS;
         if (!found && ch_mask[idx]) begin
            adv_sel = SEL_W'(idx);
            found   = 1'b1;
         end
      end
   end

   always_comb begin
      low_sel = '0;
      for (int i = CHANNELS - 1; i >= 0; i--)
         if (ch_mask[i]) low_sel = SEL_W'(i);
   end

   always_comb begin
      sel_n   = sel;
      dwell_n = dwell;
      wrap_n  = 1'b0;
      if (clr) begin
         sel_n   = low_sel;
         dwell_n = '0;
      end else if (mode) begin
         if (man_ok) sel_n = man_sel;
         dwell_n = '0;
      end else if (en && !none) begin
         // A masked-out current channel is left immediately, whatever the dwell.
         if (!ch_mask[sel] || dwell == DWELL_LAST) begin
            sel_n   = adv_sel;
            dwell_n = '0;
            wrap_n  = (adv_sel <= sel);
         end else begin
            dwell_n = dwell + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sel      <= '0;
         dwell    <= '0;
         data_out <= '0;
         valid    <= 1'b0;
         wrap     <= 1'b0;
      end else begin
         sel      <= sel_n;
         dwell    <= dwell_n;
         wrap     <= wrap_n;
         data_out <= data_in[int'(sel)*WIDTH +: WIDTH];
         valid    <= mode | ch_mask[sel];
      end
   end

endmodule

// File: doc/channel_scanner.md
CHANNEL_SCANNER -- requirements
Module: channel_scanner

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data width of each channel in bits (WIDTH >= 1).
REQ-002 The block SHALL have parameter CHANNELS, default 4, meaning the number of input channels (2..64).
REQ-003 The block SHALL have parameter DWELL, default 1, meaning the cycles spent on each channel in auto mode (1..65535).
REQ-004 The block SHALL define local SEL_W = clog2(CHANNELS), meaning the selector width in bits.
REQ-005 The block SHALL have port clk, input, 1 bit, the clock.
REQ-006 The block SHALL have port reset, input, 1 bit, the reset: synchronous, active-low.
REQ-007 The block SHALL have port en, input, 1 bit, the auto-scan advance enable.
REQ-008 The block SHALL have port clr, input, 1 bit, the synchronous scan restart.
REQ-009 The block SHALL have port mode, input, 1 bit: 0 = auto scan, 1 = manual select.
REQ-010 The block SHALL have port man_sel, input, SEL_W bits, the manual channel index.
REQ-011 The block SHALL have port ch_mask, input, CHANNELS bits, the per-channel participation mask (bit k = channel k).
REQ-012 The block SHALL have port data_in, input, CHANNELS*WIDTH bits; channel k occupies [k*WIDTH +: WIDTH].
REQ-013 The block SHALL have port sel, output, SEL_W bits, the registered current channel index.
REQ-014 The block SHALL have port data_out, output, WIDTH bits, the registered selected data.
REQ-015 The block SHALL have port valid, output, 1 bit, qualifying data_out.
REQ-016 The block SHALL have port wrap, output, 1 bit, a one-cycle scan-wrap pulse (overflow).
REQ-017 The block SHALL have port none, output, 1 bit, combinational, 1 when ch_mask == 0.

Function
REQ-018 Internal dwell counter: 16 bits; in auto mode with en=1 it SHALL count 0..DWELL-1, then return to 0 and trigger an advance on its terminal cycle.
REQ-019 Advance SHALL set sel to the next channel with its ch_mask bit set, searching upward from sel+1 modulo CHANNELS; if sel is the only enabled channel, sel holds.
REQ-020 wrap SHALL be 1 on the cycle after an advance whose new index is <= the old index; otherwise 0.
REQ-021 In auto mode with en=1, if ch_mask[sel]=0, the block SHALL advance on the next edge regardless of the dwell count and clear the dwell counter.
REQ-022 In auto mode with en=0, sel and the dwell counter SHALL hold and wrap SHALL be 0.
REQ-023 clr=1 SHALL have priority over en and mode: sel <= lowest enabled index (0 if none), dwell <= 0, wrap <= 0.
REQ-024 In manual mode, sel SHALL load man_sel when man_sel < CHANNELS, otherwise hold; dwell <= 0; wrap <= 0; ch_mask SHALL be ignored for sel.
REQ-025 Each cycle the block SHALL register data_out <= data_in channel sel (value before the edge), giving a latency of 1 cycle from sel to data_out.
REQ-026 Each cycle the block SHALL register valid <= ch_mask[sel] in auto mode, and valid <= 1 in manual mode.
REQ-027 When none=1 in auto mode, sel SHALL hold, wrap SHALL be 0, and valid SHALL be 0.
REQ-028 A mode change SHALL take effect on the same edge; switching to auto SHALL resume scanning from the current sel with the dwell counter at 0.

Reset
REQ-029 On a clk edge with reset=0, the block SHALL set sel=0, dwell=0, data_out=0, valid=0, wrap=0; reset SHALL override clr, en, and mode.
REQ-030 Reset asserted mid-dwell or mid-scan SHALL discard all state; the first edge with reset=1 SHALL resume as from power-up.

Verification
REQ-031 Defaults, ch_mask=4'hF, data_in={8'h4,8'h3,8'h2,8'h1}, en=1 after reset -> sel cycles 0,1,2,3,0; data_out 1,2,3,4 lagging by one cycle; wrap pulses when sel returns to 0.
REQ-032 DWELL=3, ch_mask=4'b1010 -> sel sequence 1,1,1,3,3,3,1; wrap pulses on each 3->1 transition.
REQ-033 Clearing the bit of the current channel mid-dwell -> advance on the next edge; all-zero mask -> none=1, valid=0, sel frozen.
REQ-034 mode=1, man_sel=2, then man_sel=3, en=0 -> sel=2 then 3, valid=1, wrap stays 0.
REQ-035 clr and en asserted together with ch_mask=4'b0100 -> sel=2, dwell=0, no wrap; reset=0 during scanning -> all outputs 0 next edge.
